// File: rtl/dma_pkg.sv
// dma_pkg: register offsets, bit indices and engine state shared by the DMA blocks
package dma_pkg;
    localparam logic [31:0] INTR_STATUS_OFF = 32'h0;
    localparam logic [31:0] INTR_MASK_OFF   = 32'h4;
    localparam logic [31:0] CH_CTRL_OFF     = 32'h0;
    localparam logic [31:0] CH_LEN_OFF      = 32'h4;
    localparam logic [31:0] CH_STATUS_OFF   = 32'h8;
    localparam logic [31:0] CH_COUNT_OFF    = 32'hC;
    localparam int CTRL_START   = 0;
    localparam int CTRL_ABORT   = 1;
    localparam int CTRL_AUTO    = 2;
    localparam int ST_PENDING   = 0;
    localparam int ST_BUSY      = 1;
    localparam int ST_DONE      = 2;
    localparam int ST_ERROR     = 3;
    localparam int ST_ABORTED   = 4;
    localparam int INTR_ERR_LSB = 16;
    typedef enum logic [1:0] {IDLE, ARB, XFER} dma_eng_state_e;
    function automatic logic [31:0] ch_addr(input logic [31:0] base, input logic [31:0] stride, input int n, input logic [31:0] off);
        return base + stride * 32'(n) + off;
    endfunction
endpackage

// File: rtl/dma_mc_engine_if.sv
// dma_mc_engine_if: register bus and data-mover beat handshake of the DMA engine
interface dma_mc_engine_if #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic            wr_en;
    logic            rd_en;
    logic [31:0]     addr;
    logic [31:0]     wdata;
    logic [31:0]     rdata;
    logic            xfer_req;
    logic [CH_W-1:0] xfer_ch;
    logic            xfer_ready;
    logic            xfer_err;
    logic            irq;
    modport slave (
        input  wr_en, rd_en, addr, wdata, xfer_ready, xfer_err,
        output rdata, xfer_req, xfer_ch, irq
    );
    modport master (
        output wr_en, rd_en, addr, wdata, xfer_ready, xfer_err,
        input  rdata, xfer_req, xfer_ch, irq
    );
endinterface

// File: rtl/dma_rr_arbiter.sv
// dma_rr_arbiter: picks the first pending channel at or after the round-robin pointer
module dma_rr_arbiter #(
    parameter int NUM_CH = 4,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] pending,
    input  logic [CH_W-1:0]   ptr,
    output logic [CH_W-1:0]   grant,
    output logic              valid
);
    int idx;
    // Scan from the farthest offset down so the nearest pending channel wins
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_CH;
            if (pending[idx]) begin
                grant = CH_W'(idx);
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/dma_mc_engine.sv
// dma_mc_engine: multi-channel DMA register file with a round-robin transfer engine
module dma_mc_engine
    import dma_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter int          CNT_W     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h400,
    parameter logic [31:0] CH_BASE   = 32'h500,
    parameter logic [31:0] CH_STRIDE = 32'h10
) (
    input logic            clk,
    input logic            rst_n,
    dma_mc_engine_if.slave bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    dma_eng_state_e    state;
    logic [CH_W-1:0]   ptr, grant, arb_grant;
    logic              arb_valid;
    logic [NUM_CH-1:0] pending, busy, done, error, aborted, auto_rs;
    logic [NUM_CH-1:0] int_done, int_err, msk_done, msk_err;
    logic [CNT_W-1:0]  len [NUM_CH];
    logic [CNT_W-1:0]  run_len [NUM_CH];
    logic [CNT_W-1:0]  count [NUM_CH];
    logic [NUM_CH-1:0] wr_ctrl, wr_len, start_hit, abort_hit;
    logic              wr_istat, wr_imask;
    logic [CNT_W-1:0]  next_count;
    logic [31:0]       rd_val;

    dma_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .pending(pending),
        .ptr(ptr),
        .grant(arb_grant),
        .valid(arb_valid)
    );

    // Write decode; start and abort only act on channels in the state that accepts them
    always_comb begin
        wr_istat   = bus.wr_en && bus.addr == BASE_ADDR + INTR_STATUS_OFF;
        wr_imask   = bus.wr_en && bus.addr == BASE_ADDR + INTR_MASK_OFF;
        next_count = count[grant] + CNT_W'(1);
        for (int n = 0; n < NUM_CH; n++) begin
            wr_ctrl[n]   = bus.wr_en && bus.addr == ch_addr(CH_BASE, CH_STRIDE, n, CH_CTRL_OFF);
            wr_len[n]    = bus.wr_en && bus.addr == ch_addr(CH_BASE, CH_STRIDE, n, CH_LEN_OFF);
            start_hit[n] = wr_ctrl[n] && bus.wdata[CTRL_START] && !pending[n] && !busy[n];
            abort_hit[n] = wr_ctrl[n] && bus.wdata[CTRL_ABORT] && (pending[n] || busy[n]);
        end
    end

    // Read mux; unmapped addresses and the W1S control bits read as zero
    always_comb begin
        rd_val = '0;
        if (bus.addr == BASE_ADDR + INTR_STATUS_OFF) begin
            rd_val[NUM_CH-1:0]             = int_done;
            rd_val[INTR_ERR_LSB +: NUM_CH] = int_err;
        end
        if (bus.addr == BASE_ADDR + INTR_MASK_OFF) begin
            rd_val[NUM_CH-1:0]             = msk_done;
            rd_val[INTR_ERR_LSB +: NUM_CH] = msk_err;
        end
        for (int n = 0; n < NUM_CH; n++) begin
            if (bus.addr == ch_addr(CH_BASE, CH_STRIDE, n, CH_CTRL_OFF))
                rd_val[CTRL_AUTO] = auto_rs[n];
            if (bus.addr == ch_addr(CH_BASE, CH_STRIDE, n, CH_LEN_OFF))
                rd_val[CNT_W-1:0] = len[n];
            if (bus.addr == ch_addr(CH_BASE, CH_STRIDE, n, CH_COUNT_OFF))
                rd_val[CNT_W-1:0] = count[n];
            if (bus.addr == ch_addr(CH_BASE, CH_STRIDE, n, CH_STATUS_OFF)) begin
                rd_val[ST_PENDING] = pending[n];
                rd_val[ST_BUSY]    = busy[n];
                rd_val[ST_DONE]    = done[n];
                rd_val[ST_ERROR]   = error[n];
                rd_val[ST_ABORTED] = aborted[n];
            end
        end
    end

    // Bus writes first, engine events last so hardware sets override a same-cycle W1C
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= '0;
            grant        <= '0;
            pending      <= '0;
            busy         <= '0;
            done         <= '0;
            error        <= '0;
            aborted      <= '0;
            auto_rs      <= '0;
            int_done     <= '0;
            int_err      <= '0;
            msk_done     <= '0;
            msk_err      <= '0;
            bus.rdata    <= '0;
            bus.xfer_req <= 1'b0;
            bus.xfer_ch  <= '0;
            bus.irq      <= 1'b0;
            for (int n = 0; n < NUM_CH; n++) begin
                len[n]     <= '0;
                run_len[n] <= '0;
                count[n]   <= '0;
            end
        end else begin
            if (bus.rd_en)
                bus.rdata <= rd_val;
            bus.irq <= |({int_err, int_done} & {msk_err, msk_done});
            if (wr_istat) begin
                int_done <= int_done & ~bus.wdata[NUM_CH-1:0];
                int_err  <= int_err & ~bus.wdata[INTR_ERR_LSB +: NUM_CH];
            end
            if (wr_imask) begin
                msk_done <= bus.wdata[NUM_CH-1:0];
                msk_err  <= bus.wdata[INTR_ERR_LSB +: NUM_CH];
            end
            for (int n = 0; n < NUM_CH; n++) begin
                if (wr_len[n])
                    len[n] <= bus.wdata[CNT_W-1:0];
                if (wr_ctrl[n])
                    auto_rs[n] <= bus.wdata[CTRL_AUTO];
                if (start_hit[n] && len[n] != '0) begin
                    pending[n] <= 1'b1;
                    done[n]    <= 1'b0;
                    error[n]   <= 1'b0;
                    aborted[n] <= 1'b0;
                    count[n]   <= '0;
                    run_len[n] <= len[n];
                end
                if (start_hit[n] && len[n] == '0) begin
                    error[n]   <= 1'b1;
                    int_err[n] <= 1'b1;
                end
                if (abort_hit[n]) begin
                    pending[n] <= 1'b0;
                    busy[n]    <= 1'b0;
                    aborted[n] <= 1'b1;
                end
            end
            case (state)
                IDLE: if (|pending) state <= ARB;
                ARB: begin
                    if (arb_valid && !abort_hit[arb_grant]) begin
                        grant              <= arb_grant;
                        ptr                <= (arb_grant == CH_W'(NUM_CH - 1)) ? '0 : arb_grant + CH_W'(1);
                        pending[arb_grant] <= 1'b0;
                        busy[arb_grant]    <= 1'b1;
                        bus.xfer_req       <= 1'b1;
                        bus.xfer_ch        <= arb_grant;
                        state              <= XFER;
                    end else
                        state <= IDLE;
                end
                XFER: begin
                    if (abort_hit[grant]) begin
                        bus.xfer_req <= 1'b0;
                        state        <= IDLE;
                    end else if (bus.xfer_ready && bus.xfer_err) begin
                        busy[grant]    <= 1'b0;
                        error[grant]   <= 1'b1;
                        int_err[grant] <= 1'b1;
                        bus.xfer_req   <= 1'b0;
                        state          <= IDLE;
                    end else if (bus.xfer_ready) begin
                        count[grant] <= next_count;
                        if (next_count == run_len[grant]) begin
                            busy[grant]     <= 1'b0;
                            done[grant]     <= 1'b1;
                            int_done[grant] <= 1'b1;
                            bus.xfer_req    <= 1'b0;
                            state           <= IDLE;
                            if (auto_rs[grant]) begin
                                count[grant]   <= '0;
                                pending[grant] <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_mc_engine.sv
// tb_dma_mc_engine: directed and randomized checks of the multi-channel DMA engine
module tb_dma_mc_engine;
    localparam int NUM_CH = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    int   beats_q[$];

    dma_mc_engine_if #(.NUM_CH(NUM_CH)) bus ();
    dma_mc_engine #(.NUM_CH(NUM_CH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Every accepted beat, by channel, in acceptance order
    always @(negedge clk)
        if (rst_n && bus.xfer_req && bus.xfer_ready) beats_q.push_back(int'(bus.xfer_ch));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.wr_en = 1'b1;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.addr  = a;
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        d = bus.rdata;
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        rd(a, v);
        check(tag, v, exp);
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (!bus.xfer_req && n < 50) begin
            tick();
            n++;
        end
        check(tag, 32'(bus.xfer_req), 32'd1);
    endtask

    task automatic chk_seq(input string tag, input int exp_q[$]);
        check({tag, "_len"}, beats_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_%0d", tag, i), (i < beats_q.size()) ? beats_q[i] : -1, exp_q[i]);
    endtask

    function automatic logic [31:0] chr(input int n, input int off);
        return 32'h500 + 32'(n) * 32'h10 + 32'(off);
    endfunction

    initial begin
        logic [31:0] v;
        logic [3:0]  sel;
        int          b, n, seen;
        int          lens[NUM_CH];
        int          exp_q[$];
        bus.wr_en = 0; bus.rd_en = 0; bus.addr = 0; bus.wdata = 0;
        bus.xfer_ready = 0; bus.xfer_err = 0;
        cycles(2);
        check("rst_rdata", bus.rdata, 0);
        check("rst_req", 32'(bus.xfer_req), 0);
        check("rst_ch", 32'(bus.xfer_ch), 0);
        check("rst_irq", 32'(bus.irq), 0);
        rst_n = 1'b1;
        tick();
        chk_rd("rst_istat", 32'h400, 0);
        chk_rd("rst_ch0_status", chr(0, 8), 0);
        chk_rd("unmapped", 32'h408, 0);

        // 1: single run of 3 beats
        wr(chr(0, 4), 3);
        bus.xfer_ready = 1;
        beats_q.delete();
        wr(chr(0, 0), 1);
        cycles(12);
        exp_q = '{0, 0, 0};
        chk_seq("t1_beats", exp_q);
        chk_rd("t1_count", chr(0, 12), 3);
        chk_rd("t1_status", chr(0, 8), 4);
        chk_rd("t1_istat", 32'h400, 1);
        chk_rd("t1_ctrl_reads0", chr(0, 0), 0);
        check("t1_irq_unmasked", 32'(bus.irq), 0);
        wr(32'h404, 1);
        tick();
        check("t1_irq_masked", 32'(bus.irq), 1);
        wr(32'h400, 32'hFFFF_FFFF);

        // 2: ch1/ch2 pending together behind ch3, then alternating auto-restart
        bus.xfer_ready = 0;
        wr(chr(3, 4), 1); wr(chr(1, 4), 2); wr(chr(2, 4), 2);
        beats_q.delete();
        wr(chr(3, 0), 1);
        wait_req("t2_req");
        wr(chr(2, 0), 1); wr(chr(1, 0), 1);
        bus.xfer_ready = 1;
        cycles(20);
        exp_q = '{3, 1, 1, 2, 2};
        chk_seq("t2_order", exp_q);
        bus.xfer_ready = 0;
        wr(chr(0, 4), 1); wr(chr(1, 4), 1);
        wr(chr(0, 0), 5);
        wait_req("t2_auto_req");
        beats_q.delete();
        wr(chr(1, 0), 5);
        bus.xfer_ready = 1;
        cycles(24);
        wr(chr(0, 0), 0); wr(chr(1, 0), 0);
        cycles(10);
        exp_q = '{0, 1, 0, 1, 0, 1};
        check("t2_auto_enough", 32'(beats_q.size() >= 6), 1);
        for (int i = 0; i < 6; i++)
            check($sformatf("t2_alt_%0d", i), (i < beats_q.size()) ? beats_q[i] : -1, exp_q[i]);
        chk_rd("t2_ch0_status", chr(0, 8), 4);
        chk_rd("t2_ch1_status", chr(1, 8), 4);
        wr(32'h400, 32'hFFFF_FFFF);

        // 3: error on the second beat
        bus.xfer_ready = 0;
        wr(chr(3, 4), 5);
        wr(chr(3, 0), 1);
        wait_req("t3_req");
        bus.xfer_ready = 1;
        tick();
        bus.xfer_err = 1;
        tick();
        bus.xfer_err = 0;
        bus.xfer_ready = 0;
        check("t3_req_drop", 32'(bus.xfer_req), 0);
        chk_rd("t3_count", chr(3, 12), 1);
        chk_rd("t3_status", chr(3, 8), 8);
        chk_rd("t3_istat", 32'h400, 32'h0008_0000);
        wr(32'h400, 32'hFFFF_FFFF);

        // 4: abort with a beat offered in the same cycle
        wr(chr(0, 4), 5);
        wr(chr(0, 0), 1);
        wait_req("t4_req");
        bus.xfer_ready = 1;
        cycles(2);
        wr(chr(0, 0), 2);
        check("t4_req_drop", 32'(bus.xfer_req), 0);
        bus.xfer_ready = 0;
        cycles(3);
        check("t4_idle", 32'(bus.xfer_req), 0);
        chk_rd("t4_count", chr(0, 12), 2);
        chk_rd("t4_status", chr(0, 8), 32'h10);
        chk_rd("t4_istat", 32'h400, 0);

        // 5: W1C collides with completion, later W1C clears and irq lags a cycle
        wr(chr(0, 4), 1);
        wr(chr(0, 0), 1);
        wait_req("t5_req");
        bus.addr = 32'h400; bus.wdata = 1; bus.wr_en = 1; bus.xfer_ready = 1;
        tick();
        bus.wr_en = 0; bus.xfer_ready = 0;
        chk_rd("t5_set_wins", 32'h400, 1);
        check("t5_irq_high", 32'(bus.irq), 1);
        wr(32'h400, 1);
        check("t5_irq_lags", 32'(bus.irq), 1);
        tick();
        check("t5_irq_falls", 32'(bus.irq), 0);

        // Randomized rounds: a blocker holds the engine while others queue up
        for (int r = 0; r < 8; r++) begin
            wr(32'h400, 32'hFFFF_FFFF);
            b = $urandom_range(0, NUM_CH - 1);
            sel = 4'($urandom_range(0, 15));
            sel[b] = 1'b1;
            bus.xfer_ready = 0;
            for (int c = 0; c < NUM_CH; c++) begin
                lens[c] = $urandom_range(1, 6);
                if (sel[c]) wr(chr(c, 4), 32'(lens[c]));
            end
            beats_q.delete();
            wr(chr(b, 0), 1);
            wait_req("rnd_req");
            for (int k = NUM_CH - 1; k >= 1; k--)
                if (sel[(b + k) % NUM_CH]) wr(chr((b + k) % NUM_CH, 0), 1);
            exp_q.delete();
            for (int k = 0; k < NUM_CH; k++)
                if (sel[(b + k) % NUM_CH])
                    repeat (lens[(b + k) % NUM_CH]) exp_q.push_back((b + k) % NUM_CH);
            n = 0;
            while (beats_q.size() < exp_q.size() && n < 400) begin
                bus.xfer_ready = ($urandom_range(0, 9) < 6);
                tick();
                n++;
            end
            bus.xfer_ready = 1;
            cycles(8);
            bus.xfer_ready = 0;
            chk_seq($sformatf("rnd%0d", r), exp_q);
            for (int c = 0; c < NUM_CH; c++)
                if (sel[c]) begin
                    chk_rd($sformatf("rnd%0d_count%0d", r, c), chr(c, 12), 32'(lens[c]));
                    chk_rd($sformatf("rnd%0d_status%0d", r, c), chr(c, 8), 4);
                end
            chk_rd($sformatf("rnd%0d_istat", r), 32'h400, 32'(sel));
        end

        // 6: reset in the middle of a transfer
        wr(chr(1, 4), 10);
        rd(chr(1, 4), v);
        check("t6_rdata_loaded", v, 10);
        wr(chr(1, 0), 1);
        wait_req("t6_req");
        rst_n = 0;
        tick();
        check("t6_rst_req", 32'(bus.xfer_req), 0);
        check("t6_rst_ch", 32'(bus.xfer_ch), 0);
        check("t6_rst_irq", 32'(bus.irq), 0);
        check("t6_rst_rdata", bus.rdata, 0);
        rst_n = 1;
        tick();
        chk_rd("t6_ch1_status", chr(1, 8), 0);
        chk_rd("t6_ch1_len", chr(1, 4), 0);
        chk_rd("t6_mask", 32'h404, 0);

        // 6: start with LEN=0
        wr(chr(2, 0), 1);
        seen = 0;
        repeat (5) begin
            seen |= int'(bus.xfer_req);
            tick();
        end
        check("t6_len0_noreq", 32'(seen), 0);
        chk_rd("t6_len0_status", chr(2, 8), 8);
        chk_rd("t6_len0_istat", 32'h400, 32'h0004_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
